// File: rtl/std_gray_counter_array.sv
// rtl/std_gray_counter_array.sv - bank of independent up/down counters with gray-coded registered outputs
//
// Purpose: CHANNELS independent counters. Each keeps a binary register and a
// gray register, and the gray register is loaded from gray(bin_next), so
// o_count is glitch-free for sampling in another clock domain.
//
// Ports (all per-channel vectors are packed, channel c at [c*WIDTH +: WIDTH] or [c]):
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_clear        load INITIAL_COUNT (highest priority)
//   i_clear_sat    clear the sticky saturation flag
//   i_set          load i_set_value, clamped to [MIN_COUNT, MAX_COUNT]
//   i_set_value    binary load values
//   i_up, i_down   step controls; both together hold
//   o_count        registered gray count
//   o_count_next   combinational gray count for the next cycle
//   o_count_bin    registered binary count
//   o_wrap_around  combinational; this cycle's step wraps at a bound
//   o_at_max       registered; count == MAX_COUNT
//   o_at_min       registered; count == MIN_COUNT
//   o_saturated    sticky; a step was blocked at a bound (WRAP_AROUND = 0 only)
module std_gray_counter_array #(
  parameter int               WIDTH         = 4,
  parameter int               CHANNELS      = 2,
  parameter logic [WIDTH-1:0] MAX_COUNT     = '1,
  parameter logic [WIDTH-1:0] MIN_COUNT     = '0,
  parameter logic [WIDTH-1:0] INITIAL_COUNT = MIN_COUNT,
  parameter bit               WRAP_AROUND   = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_clear,
  input  logic [CHANNELS-1:0]       i_clear_sat,
  input  logic [CHANNELS-1:0]       i_set,
  input  logic [CHANNELS*WIDTH-1:0] i_set_value,
  input  logic [CHANNELS-1:0]       i_up,
  input  logic [CHANNELS-1:0]       i_down,
  output logic [CHANNELS*WIDTH-1:0] o_count,
  output logic [CHANNELS*WIDTH-1:0] o_count_next,
  output logic [CHANNELS*WIDTH-1:0] o_count_bin,
  output logic [CHANNELS-1:0]       o_wrap_around,
  output logic [CHANNELS-1:0]       o_at_max,
  output logic [CHANNELS-1:0]       o_at_min,
  output logic [CHANNELS-1:0]       o_saturated
);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] set_val;
    logic [WIDTH-1:0] set_clamped;
    logic             above_max;
    logic             below_min;
    logic             wrap;
    logic             sat_event;
    logic             at_max_q;
    logic             at_min_q;
    logic             sat_q;

    assign set_val = i_set_value[c*WIDTH +: WIDTH];

    // Range checks are elaborated away when the bound is the natural limit
    // of the counter width, where the comparison could never be true.
    if (MAX_COUNT == {WIDTH{1'b1}}) begin : g_no_max_chk
      assign above_max = 1'b0;
    end else begin : g_max_chk
      assign above_max = (set_val > MAX_COUNT);
    end

    if (MIN_COUNT == {WIDTH{1'b0}}) begin : g_no_min_chk
      assign below_min = 1'b0;
    end else begin : g_min_chk
      assign below_min = (set_val < MIN_COUNT);
    end

    always_comb begin
      set_clamped = set_val;
      if (above_max) begin
        set_clamped = MAX_COUNT;
      end else if (below_min) begin
        set_clamped = MIN_COUNT;
      end
    end

    always_comb begin
      bin_next  = bin_q;
      wrap      = 1'b0;
      sat_event = 1'b0;
      if (i_clear[c]) begin
        bin_next = INITIAL_COUNT;
      end else if (i_set[c]) begin
        bin_next = set_clamped;
      end else if (i_up[c] && !i_down[c]) begin
        if (bin_q == MAX_COUNT) begin
          if (WRAP_AROUND) begin
            bin_next = MIN_COUNT;
            wrap     = 1'b1;
          end else begin
            sat_event = 1'b1;
          end
        end else begin
          bin_next = bin_q + WIDTH'(1);
        end
      end else if (i_down[c] && !i_up[c]) begin
        if (bin_q == MIN_COUNT) begin
          if (WRAP_AROUND) begin
            bin_next = MAX_COUNT;
            wrap     = 1'b1;
          end else begin
            sat_event = 1'b1;
          end
        end else begin
          bin_next = bin_q - WIDTH'(1);
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        bin_q    <= INITIAL_COUNT;
        gray_q   <= to_gray(INITIAL_COUNT);
        at_max_q <= (INITIAL_COUNT == MAX_COUNT);
        at_min_q <= (INITIAL_COUNT == MIN_COUNT);
        sat_q    <= 1'b0;
      end else begin
        bin_q    <= bin_next;
        gray_q   <= to_gray(bin_next);
        at_max_q <= (bin_next == MAX_COUNT);
        at_min_q <= (bin_next == MIN_COUNT);
        // A new blocked step beats a simultaneous clear request.
        if (sat_event) begin
          sat_q <= 1'b1;
        end else if (i_clear_sat[c]) begin
          sat_q <= 1'b0;
        end
      end
    end

    assign o_count[c*WIDTH +: WIDTH]      = gray_q;
    assign o_count_bin[c*WIDTH +: WIDTH]  = bin_q;
    assign o_count_next[c*WIDTH +: WIDTH] = to_gray(bin_next);
    assign o_wrap_around[c]               = wrap;
    assign o_at_max[c]                    = at_max_q;
    assign o_at_min[c]                    = at_min_q;
    assign o_saturated[c]                 = sat_q;
  end

endmodule

// File: tb/tb_std_gray_counter_array.sv
// tb/tb_std_gray_counter_array.sv - directed self-checking bench for std_gray_counter_array
module tb_std_gray_counter_array;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=3, full range, wrapping
  logic [1:0] a_clear, a_clear_sat, a_set, a_up, a_down;
  logic [5:0] a_set_value;
  logic [5:0] a_count, a_count_next, a_bin;
  logic [1:0] a_wrap, a_at_max, a_at_min, a_sat;

  // Instances B (range 2..5, saturating) and C (full range, saturating) share inputs
  logic [1:0] bc_clear, bc_clear_sat, bc_set, bc_up, bc_down;
  logic [5:0] bc_set_value;
  logic [5:0] b_count, b_count_next, b_bin;
  logic [1:0] b_wrap, b_at_max, b_at_min, b_sat;
  logic [5:0] c_count, c_count_next, c_bin;
  logic [1:0] c_wrap, c_at_max, c_at_min, c_sat;

  std_gray_counter_array #(.WIDTH(3), .CHANNELS(2)) dut_a (
    .i_clk(clk), .i_rst(rst_n),
    .i_clear(a_clear), .i_clear_sat(a_clear_sat), .i_set(a_set),
    .i_set_value(a_set_value), .i_up(a_up), .i_down(a_down),
    .o_count(a_count), .o_count_next(a_count_next), .o_count_bin(a_bin),
    .o_wrap_around(a_wrap), .o_at_max(a_at_max), .o_at_min(a_at_min),
    .o_saturated(a_sat)
  );

  std_gray_counter_array #(.WIDTH(3), .CHANNELS(2), .MAX_COUNT(3'd5),
                           .MIN_COUNT(3'd2), .INITIAL_COUNT(3'd2),
                           .WRAP_AROUND(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst_n),
    .i_clear(bc_clear), .i_clear_sat(bc_clear_sat), .i_set(bc_set),
    .i_set_value(bc_set_value), .i_up(bc_up), .i_down(bc_down),
    .o_count(b_count), .o_count_next(b_count_next), .o_count_bin(b_bin),
    .o_wrap_around(b_wrap), .o_at_max(b_at_max), .o_at_min(b_at_min),
    .o_saturated(b_sat)
  );

  std_gray_counter_array #(.WIDTH(3), .CHANNELS(2), .WRAP_AROUND(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst_n),
    .i_clear(bc_clear), .i_clear_sat(bc_clear_sat), .i_set(bc_set),
    .i_set_value(bc_set_value), .i_up(bc_up), .i_down(bc_down),
    .o_count(c_count), .o_count_next(c_count_next), .o_count_bin(c_bin),
    .o_wrap_around(c_wrap), .o_at_max(c_at_max), .o_at_min(c_at_min),
    .o_saturated(c_sat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_clear = '0; a_clear_sat = '0; a_set = '0; a_up = '0; a_down = '0; a_set_value = '0;
    bc_clear = '0; bc_clear_sat = '0; bc_set = '0; bc_up = '0; bc_down = '0; bc_set_value = '0;
    tick;
    tick;
    checks++;
    if (a_count !== 6'o00 || a_bin !== 6'o00) begin
      errors++; $display("FAIL reset_a_count: got gray=%o bin=%o expected 00 00", a_count, a_bin);
    end
    checks++;
    if (a_at_min !== 2'b11 || a_at_max !== 2'b00 || a_sat !== 2'b00) begin
      errors++; $display("FAIL reset_a_flags: got min=%b max=%b sat=%b expected 11 00 00", a_at_min, a_at_max, a_sat);
    end
    checks++;
    if (b_bin !== 6'o22 || b_count !== 6'o33 || b_at_min !== 2'b11) begin
      errors++; $display("FAIL reset_b: got bin=%o gray=%o min=%b expected 22 33 11", b_bin, b_count, b_at_min);
    end
    checks++;
    if (a_count_next !== 6'o00 || a_wrap !== 2'b00) begin
      errors++; $display("FAIL reset_a_next: got next=%o wrap=%b expected 00 00", a_count_next, a_wrap);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap;
    logic [2:0] exp_gray [9];
    exp_gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    a_up = 2'b01;
    #1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (a_count[2:0] !== exp_gray[i]) begin
        errors++; $display("FAIL up_gray[%0d]: got %b expected %b", i, a_count[2:0], exp_gray[i]);
      end
      checks++;
      if (a_wrap[0] !== (i == 7)) begin
        errors++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, a_wrap[0], (i == 7));
      end
      checks++;
      if (a_count[5:3] !== 3'b000 || a_wrap[1] !== 1'b0) begin
        errors++; $display("FAIL up_ch1[%0d]: got %b/%b expected 000/0", i, a_count[5:3], a_wrap[1]);
      end
      tick;
    end
    a_up = 2'b00;
  endtask

  task automatic test_down_wrap;
    logic [2:0] prev;
    a_clear = 2'b01;
    tick;
    a_clear = 2'b00;
    checks++;
    if (a_bin[2:0] !== 3'd0) begin
      errors++; $display("FAIL down_clear: got %0d expected 0", a_bin[2:0]);
    end
    a_down = 2'b01;
    #1;
    checks++;
    if (a_wrap[0] !== 1'b1 || a_count_next[2:0] !== 3'b100) begin
      errors++; $display("FAIL down_first: got wrap=%b next=%b expected 1 100", a_wrap[0], a_count_next[2:0]);
    end
    prev = a_count[2:0];
    tick;
    checks++;
    if (a_bin[2:0] !== 3'd7 || $countones(prev ^ a_count[2:0]) !== 1) begin
      errors++; $display("FAIL down_step1: got bin=%0d gray=%b expected 7 100", a_bin[2:0], a_count[2:0]);
    end
    checks++;
    if (a_wrap[0] !== 1'b0 || a_at_max[0] !== 1'b1) begin
      errors++; $display("FAIL down_step1_flags: got wrap=%b max=%b expected 0 1", a_wrap[0], a_at_max[0]);
    end
    prev = a_count[2:0];
    tick;
    checks++;
    if (a_bin[2:0] !== 3'd6 || $countones(prev ^ a_count[2:0]) !== 1) begin
      errors++; $display("FAIL down_step2: got bin=%0d gray=%b expected 6 101", a_bin[2:0], a_count[2:0]);
    end
    a_down = 2'b00;
  endtask

  task automatic test_saturate;
    bc_set_value = {3'd0, 3'd6};
    bc_set = 2'b01;
    tick;
    bc_set = 2'b00;
    checks++;
    if (b_bin[2:0] !== 3'd5 || b_at_max[0] !== 1'b1 || b_bin[5:3] !== 3'd2) begin
      errors++; $display("FAIL sat_set6: got bin=%o max=%b expected 25 1", b_bin, b_at_max[0]);
    end
    bc_up = 2'b01;
    #1;
    checks++;
    if (b_wrap[0] !== 1'b0 || b_count_next[2:0] !== 3'b111 || b_sat !== 2'b00) begin
      errors++; $display("FAIL sat_up_comb: got wrap=%b next=%b sat=%b expected 0 111 00", b_wrap[0], b_count_next[2:0], b_sat);
    end
    tick;
    bc_up = 2'b00;
    checks++;
    if (b_bin[2:0] !== 3'd5 || b_sat !== 2'b01) begin
      errors++; $display("FAIL sat_up_hold: got bin=%0d sat=%b expected 5 01", b_bin[2:0], b_sat);
    end
    checks++;
    if (c_bin[2:0] !== 3'd7 || c_sat !== 2'b00) begin
      errors++; $display("FAIL sat_c_step: got bin=%0d sat=%b expected 7 00", c_bin[2:0], c_sat);
    end
    bc_clear_sat = 2'b01;
    tick;
    bc_clear_sat = 2'b00;
    checks++;
    if (b_sat !== 2'b00) begin
      errors++; $display("FAIL sat_clear: got %b expected 00", b_sat);
    end
    bc_set_value = {3'd0, 3'd1};
    bc_set = 2'b01;
    tick;
    bc_set = 2'b00;
    checks++;
    if (b_bin[2:0] !== 3'd2 || b_at_min[0] !== 1'b1 || b_at_max[0] !== 1'b0) begin
      errors++; $display("FAIL sat_set1: got bin=%0d min=%b max=%b expected 2 1 0", b_bin[2:0], b_at_min[0], b_at_max[0]);
    end
    bc_down = 2'b01;
    tick;
    bc_down = 2'b00;
    checks++;
    if (b_bin[2:0] !== 3'd2 || b_sat !== 2'b01 || c_bin[2:0] !== 3'd0) begin
      errors++; $display("FAIL sat_down_min: got bin=%0d sat=%b cbin=%0d expected 2 01 0", b_bin[2:0], b_sat, c_bin[2:0]);
    end
    bc_clear_sat = 2'b01;
    tick;
    bc_clear_sat = 2'b00;
  endtask

  task automatic test_priority;
    a_set_value = {3'd0, 3'd3};
    a_set = 2'b01;
    tick;
    checks++;
    if (a_bin[2:0] !== 3'd3) begin
      errors++; $display("FAIL prio_preset: got %0d expected 3", a_bin[2:0]);
    end
    a_clear = 2'b01;
    a_set_value = {3'd0, 3'd4};
    a_up = 2'b01;
    #1;
    checks++;
    if (a_count_next[2:0] !== 3'b000 || a_wrap[0] !== 1'b0) begin
      errors++; $display("FAIL prio_clear_comb: got next=%b wrap=%b expected 000 0", a_count_next[2:0], a_wrap[0]);
    end
    tick;
    a_clear = 2'b00;
    checks++;
    if (a_bin[2:0] !== 3'd0) begin
      errors++; $display("FAIL prio_clear: got %0d expected 0", a_bin[2:0]);
    end
    tick;
    a_set = 2'b00;
    checks++;
    if (a_bin[2:0] !== 3'd4 || a_count[2:0] !== 3'b110) begin
      errors++; $display("FAIL prio_set: got bin=%0d gray=%b expected 4 110", a_bin[2:0], a_count[2:0]);
    end
    a_down = 2'b01;
    #1;
    checks++;
    if (a_wrap[0] !== 1'b0 || a_count_next[2:0] !== 3'b110) begin
      errors++; $display("FAIL prio_updown_comb: got wrap=%b next=%b expected 0 110", a_wrap[0], a_count_next[2:0]);
    end
    tick;
    a_up = 2'b00;
    a_down = 2'b00;
    checks++;
    if (a_bin[2:0] !== 3'd4 || a_bin[5:3] !== 3'd0) begin
      errors++; $display("FAIL prio_updown: got bin=%o expected 04", a_bin);
    end
  endtask

  task automatic test_sat_set_wins;
    bc_set_value = {3'd0, 3'd7};
    bc_set = 2'b01;
    tick;
    bc_set = 2'b00;
    checks++;
    if (c_bin[2:0] !== 3'd7 || c_at_max[0] !== 1'b1 || b_bin[2:0] !== 3'd5) begin
      errors++; $display("FAIL win_set7: got cbin=%0d cmax=%b bbin=%0d expected 7 1 5", c_bin[2:0], c_at_max[0], b_bin[2:0]);
    end
    bc_up = 2'b01;
    bc_clear_sat = 2'b01;
    tick;
    bc_up = 2'b00;
    bc_clear_sat = 2'b00;
    checks++;
    if (c_sat !== 2'b01 || c_bin[2:0] !== 3'd7) begin
      errors++; $display("FAIL win_c_sat: got sat=%b bin=%0d expected 01 7", c_sat, c_bin[2:0]);
    end
    checks++;
    if (b_sat !== 2'b01 || a_sat !== 2'b00) begin
      errors++; $display("FAIL win_other: got bsat=%b asat=%b expected 01 00", b_sat, a_sat);
    end
  endtask

  task automatic test_reset_mid;
    a_set_value = {3'd0, 3'd5};
    a_set = 2'b01;
    tick;
    a_set = 2'b00;
    a_up = 2'b01;
    checks++;
    if (a_bin[2:0] !== 3'd5) begin
      errors++; $display("FAIL mid_preset: got %0d expected 5", a_bin[2:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_bin !== 6'o00 || a_count !== 6'o00 || a_at_min !== 2'b11) begin
      errors++; $display("FAIL mid_reset_a: got bin=%o gray=%o min=%b expected 00 00 11", a_bin, a_count, a_at_min);
    end
    checks++;
    if (c_sat !== 2'b00 || b_sat !== 2'b00 || b_bin !== 6'o22) begin
      errors++; $display("FAIL mid_reset_sat: got csat=%b bsat=%b bbin=%o expected 00 00 22", c_sat, b_sat, b_bin);
    end
    tick;
    checks++;
    if (a_bin[2:0] !== 3'd0) begin
      errors++; $display("FAIL mid_reset_hold: got %0d expected 0", a_bin[2:0]);
    end
    a_up = 2'b00;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_sat_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
